if_id_pipe_reg: RTL and testbench

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

---
 rtl/if_id_pipe_reg.sv | 126 ++++++++++++
 tb/tb_if_id_pipe_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: 2-entry skid buffer between fetch and decode, FIFO order kept.
// Latency: one cycle from input acceptance to out_* when the buffer is empty ahead of it.
// Backpressure: in_ready is derived only from registered state (low while skid holds an entry).
module if_id_pipe_reg #(
  parameter int                  ADDR_W    = 16,
  parameter int                  INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_hit,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_hit,
  output logic [15:0]        bubble_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
    logic               hit;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_ent;
  logic   accept_in, accept_out;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ent = '{addr: in_addr, instr: in_instr, hit: in_hit};

  // Handshake qualifiers; in_ready comes from state only, so out_ready never reaches it.
  assign in_ready   = (state_q != SKID);
  assign out_valid  = (state_q != EMPTY);
  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;

  // State register and decode-idle counter; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      bubble_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      if (out_ready && !out_valid && !flush && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  // Next state and which entry register loads from where.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_in) begin
            state_d      = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (accept_in && accept_out) begin
            load_main_in = 1'b1;
          end else if (accept_in && !out_ready) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (accept_out) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (accept_out) begin
            state_d        = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry storage; contents are don't-care while their state bit says empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)
        main_q <= in_ent;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_ent;
    end
  end

  // Decode-side view: the main entry when valid, otherwise a NOP with zeroed sideband.
  always_comb begin
    out_addr  = '0;
    out_instr = NOP_INSTR;
    out_hit   = 1'b0;
    if (out_valid) begin
      out_addr  = main_q.addr;
      out_instr = main_q.instr;
      out_hit   = main_q.hit;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // 16-bit default instance
  logic        a_in_valid, a_in_ready, a_in_hit, a_flush;
  logic        a_out_valid, a_out_ready, a_out_hit;
  logic [15:0] a_in_addr, a_in_instr, a_out_addr, a_out_instr, a_bubble;

  // 32-bit instance with non-zero NOP
  logic        b_in_valid, b_in_ready, b_in_hit, b_flush;
  logic        b_out_valid, b_out_ready, b_out_hit;
  logic [31:0] b_in_addr, b_in_instr, b_out_addr, b_out_instr;
  logic [15:0] b_bubble;

  always #5 clk = ~clk;

  if_id_pipe_reg dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_addr(a_in_addr), .in_instr(a_in_instr), .in_hit(a_in_hit),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_addr(a_out_addr), .out_instr(a_out_instr), .out_hit(a_out_hit),
    .bubble_cnt(a_bubble)
  );

  if_id_pipe_reg #(.ADDR_W(32), .INSTR_W(32), .NOP_INSTR(32'h0000_0013)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_addr(b_in_addr), .in_instr(b_in_instr), .in_hit(b_in_hit),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_addr(b_out_addr), .out_instr(b_out_instr), .out_hit(b_out_hit),
    .bubble_cnt(b_bubble)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set before the call, outputs settled on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [15:0] addr, input logic [15:0] instr, input logic hit);
    a_in_valid = 1'b1;
    a_in_addr  = addr;
    a_in_instr = instr;
    a_in_hit   = hit;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_addr = 0; a_in_instr = 0; a_in_hit = 0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_addr = 0; b_in_instr = 0; b_in_hit = 0; b_flush = 0; b_out_ready = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_instr", {16'd0, a_out_instr}, 32'd0);
    chk("rst_out_addr", {16'd0, a_out_addr}, 32'd0);
    chk("rst_out_hit", {31'd0, a_out_hit}, 32'd0);
    chk("rst_bubble", {16'd0, a_bubble}, 32'd0);
    chk("b_idle_nop", b_out_instr, 32'h0000_0013);
    chk("b_idle_addr", b_out_addr, 32'd0);

    // 32-bit payload passes through unmodified
    b_out_ready = 1; b_in_valid = 1; b_in_addr = 32'hDEAD_BEEF; b_in_instr = 32'hCAFE_F00D; b_in_hit = 1;
    tick();
    b_in_valid = 0;
    chk("b_out_addr", b_out_addr, 32'hDEAD_BEEF);
    chk("b_out_instr", b_out_instr, 32'hCAFE_F00D);
    chk("b_out_hit", {31'd0, b_out_hit}, 32'd1);
    tick();
    chk("b_drain_nop", b_out_instr, 32'h0000_0013);

    // Streaming; the first edge is idle with out_ready=1, so bubble_cnt becomes 1
    a_out_ready = 1;
    a_push(16'h0000, 16'hA000, 1'b1);
    tick();
    chk("s0_valid", {31'd0, a_out_valid}, 32'd1);
    chk("s0_addr", {16'd0, a_out_addr}, 32'h0000);
    chk("s0_hit", {31'd0, a_out_hit}, 32'd1);
    chk("s0_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_push(16'h0002, 16'hA002, 1'b0);
    tick();
    chk("s1_addr", {16'd0, a_out_addr}, 32'h0002);
    chk("s1_instr", {16'd0, a_out_instr}, 32'hA002);
    chk("s1_valid", {31'd0, a_out_valid}, 32'd1);
    chk("s1_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_push(16'h0004, 16'hA004, 1'b1);
    tick();
    chk("s2_addr", {16'd0, a_out_addr}, 32'h0004);
    chk("s2_valid", {31'd0, a_out_valid}, 32'd1);
    a_in_valid = 0;
    tick();
    chk("s_drain_valid", {31'd0, a_out_valid}, 32'd0);
    chk("s_drain_addr", {16'd0, a_out_addr}, 32'd0);
    chk("s_drain_hit", {31'd0, a_out_hit}, 32'd0);
    chk("s_bubble", {16'd0, a_bubble}, 32'd1);

    // Backpressure into skid, then in-order drain
    a_out_ready = 0;
    a_push(16'h0010, 16'h1111, 1'b0);
    tick();
    chk("bp_first", {16'd0, a_out_instr}, 32'h1111);
    chk("bp_first_rdy", {31'd0, a_in_ready}, 32'd1);
    a_push(16'h0020, 16'h2222, 1'b1);
    tick();
    chk("bp_skid_rdy", {31'd0, a_in_ready}, 32'd0);
    chk("bp_skid_instr", {16'd0, a_out_instr}, 32'h1111);
    a_push(16'h0030, 16'h9999, 1'b0);
    tick();
    chk("bp_hold_instr", {16'd0, a_out_instr}, 32'h1111);
    chk("bp_hold_addr", {16'd0, a_out_addr}, 32'h0010);
    chk("bp_hold_rdy", {31'd0, a_in_ready}, 32'd0);
    a_in_valid = 0;
    a_out_ready = 1;
    tick();
    chk("bp_second", {16'd0, a_out_instr}, 32'h2222);
    chk("bp_second_hit", {31'd0, a_out_hit}, 32'd1);
    chk("bp_second_rdy", {31'd0, a_in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, a_out_valid}, 32'd0);
    chk("bp_bubble", {16'd0, a_bubble}, 32'd1);

    // Flush while in SKID; the entry offered alongside flush is dropped
    a_out_ready = 0;
    a_push(16'h0040, 16'h4444, 1'b0);
    tick();
    a_push(16'h0050, 16'h5555, 1'b0);
    tick();
    chk("fl_skid_rdy", {31'd0, a_in_ready}, 32'd0);
    a_flush = 1;
    a_push(16'h0060, 16'h3333, 1'b1);
    tick();
    a_flush = 0;
    a_in_valid = 0;
    chk("fl_valid", {31'd0, a_out_valid}, 32'd0);
    chk("fl_instr", {16'd0, a_out_instr}, 32'd0);
    chk("fl_rdy", {31'd0, a_in_ready}, 32'd1);
    a_out_ready = 1;
    tick();
    chk("fl_no_3333", {16'd0, a_out_instr}, 32'd0);
    chk("fl_bubble", {16'd0, a_bubble}, 32'd2);
    // Flush from EMPTY with in_valid: entry ignored, no bubble counted
    a_flush = 1;
    a_push(16'h0070, 16'h3333, 1'b1);
    tick();
    a_flush = 0;
    a_in_valid = 0;
    chk("fl_idle_valid", {31'd0, a_out_valid}, 32'd0);
    chk("fl_idle_bubble", {16'd0, a_bubble}, 32'd2);

    // Build bubble_cnt to 5, fill the skid, then reset with flush and handshakes active
    tick();
    tick();
    tick();
    chk("rm_bubble5", {16'd0, a_bubble}, 32'd5);
    a_out_ready = 0;
    a_push(16'h0080, 16'h6666, 1'b0);
    tick();
    a_push(16'h0090, 16'h7777, 1'b0);
    tick();
    chk("rm_skid_rdy", {31'd0, a_in_ready}, 32'd0);
    chk("rm_bubble_kept", {16'd0, a_bubble}, 32'd5);
    rst = 1; a_flush = 1; a_out_ready = 1;
    a_push(16'h00A0, 16'h8888, 1'b1);
    tick();
    rst = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0;
    chk("rm_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rm_rdy", {31'd0, a_in_ready}, 32'd1);
    chk("rm_bubble", {16'd0, a_bubble}, 32'd0);
    chk("rm_instr", {16'd0, a_out_instr}, 32'd0);

    // Saturation of bubble_cnt
    a_out_ready = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, a_bubble}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'd0, a_bubble}, 32'h0000_FFFF);
    repeat (5) tick();
    chk("sat_hold", {16'd0, a_bubble}, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
